// File: rtl/lc3b_types.sv
// Shared LC-3b control types: opcodes, ALU operations and the 4-way mux select.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef logic [1:0] lc3b_sel4mux;

    localparam lc3b_sel4mux ALUMUX_SR2  = 2'd0;
    localparam lc3b_sel4mux ALUMUX_ADJ6 = 2'd1;
    localparam lc3b_sel4mux ALUMUX_IMM5 = 2'd2;

endpackage

// File: rtl/mem_timer.sv
// Wait-cycle counter for memory accesses; expired rises once LIMIT unanswered cycles have elapsed.
module mem_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/control_fsm.sv
// LC-3b multicycle control FSM. Define CONTROL_MEM_TIMEOUT_EN to abort memory waits
// after MEM_TIMEOUT unanswered cycles (mem_error pulses on the abort cycle).
module control_fsm
    import lc3b_types::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  lc3b_opcode  opcode,
    input  logic        branch_enable,
    input  logic        imm5_enable,
    input  logic        imm11_enable,
    input  logic        mem_resp,
    output logic        pcmux_sel,
    output logic        load_pc,
    output logic        storemux_sel,
    output logic        load_ir,
    output logic        load_regfile,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_cc,
    output logic        regfilemux_sel,
    output logic        marmux_sel,
    output logic        mdrmux_sel,
    output lc3b_sel4mux alumux_sel,
    output lc3b_aluop   aluop,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic        mem_error,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        s_fetch1, s_fetch2, s_fetch3, s_decode,
        s_add, s_and, s_not, s_br, s_br_taken,
        s_calc_addr, s_ldr1, s_ldr2, s_str1, s_str2
    } state_t;

    state_t state, next_state;
    logic   in_wait;
    logic   timeout;
    logic   unused_ok;

    // Memory handshake: mem_read/mem_write stay high for the whole wait state and
    // the request completes on the cycle mem_resp is high; mem_resp elsewhere is ignored.
    assign in_wait   = (state == s_fetch2) || (state == s_ldr1) || (state == s_str2);
    assign state_dbg = state;

`ifdef CONTROL_MEM_TIMEOUT_EN
    mem_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_wait),
        .inc     (in_wait && !mem_resp),
        .expired (timeout)
    );
    assign unused_ok = imm11_enable;
`else
    assign timeout   = 1'b0;
    assign unused_ok = &{1'b0, imm11_enable, MEM_TIMEOUT[0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= s_fetch1;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        pcmux_sel       = 1'b0;
        load_pc         = 1'b0;
        storemux_sel    = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        regfilemux_sel  = 1'b0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        alumux_sel      = ALUMUX_SR2;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_error       = 1'b0;

        // Outputs stay quiet for as long as reset is held, even though state is already fetch1.
        if (reset_n) begin
            unique case (state)
                s_fetch1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                    next_state = s_fetch2;
                end
                s_fetch2: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    if (mem_resp) begin
                        next_state = s_fetch3;
                    end else if (timeout) begin
                        mem_error  = 1'b1;
                        next_state = s_fetch1;
                    end
                end
                s_fetch3: begin
                    load_ir    = 1'b1;
                    next_state = s_decode;
                end
                s_decode: begin
                    unique case (opcode)
                        op_add:         next_state = s_add;
                        op_and:         next_state = s_and;
                        op_not:         next_state = s_not;
                        op_br:          next_state = s_br;
                        op_ldr, op_str: next_state = s_calc_addr;
                        default:        next_state = s_fetch1;
                    endcase
                end
                s_add, s_and: begin
                    aluop        = (state == s_and) ? alu_and : alu_add;
                    alumux_sel   = imm5_enable ? ALUMUX_IMM5 : ALUMUX_SR2;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    next_state   = s_fetch1;
                end
                s_not: begin
                    aluop        = alu_not;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    next_state   = s_fetch1;
                end
                s_br: begin
                    next_state = branch_enable ? s_br_taken : s_fetch1;
                end
                s_br_taken: begin
                    pcmux_sel  = 1'b1;
                    load_pc    = 1'b1;
                    next_state = s_fetch1;
                end
                s_calc_addr: begin
                    alumux_sel = ALUMUX_ADJ6;
                    load_mar   = 1'b1;
                    if (opcode == op_ldr) begin
                        next_state = s_ldr1;
                    end else if (opcode == op_str) begin
                        next_state = s_str1;
                    end else begin
                        next_state = s_fetch1;
                    end
                end
                s_ldr1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    if (mem_resp) begin
                        next_state = s_ldr2;
                    end else if (timeout) begin
                        mem_error  = 1'b1;
                        next_state = s_fetch1;
                    end
                end
                s_ldr2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    next_state     = s_fetch1;
                end
                s_str1: begin
                    storemux_sel = 1'b1;
                    aluop        = alu_pass;
                    load_mdr     = 1'b1;
                    next_state   = s_str2;
                end
                s_str2: begin
                    mem_write       = 1'b1;
                    mem_byte_enable = 2'b11;
                    if (mem_resp) begin
                        next_state = s_fetch1;
                    end else if (timeout) begin
                        mem_error  = 1'b1;
                        next_state = s_fetch1;
                    end
                end
                default: begin
                    next_state = s_fetch1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected control sequences built from the
// instruction rules, checked cycle by cycle; timeout cases run when CONTROL_MEM_TIMEOUT_EN is set.
module tb_control_fsm;
  import lc3b_types::*;

  localparam int TB_TIMEOUT = 4;
  localparam int W = 21;

  typedef struct packed {
    logic       pcmux_sel;
    logic       load_pc;
    logic       storemux_sel;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic       regfilemux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] alumux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       mem_error;
  } ctl_t;

  typedef struct packed {
    logic       resp;
    logic [3:0] op;
    logic       br;
    logic       imm5;
  } stim_t;

`ifdef CONTROL_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3b_opcode  opcode;
  logic        branch_enable, imm5_enable, imm11_enable, mem_resp;
  logic        pcmux_sel, load_pc, storemux_sel, load_ir, load_regfile, load_mar;
  logic        load_mdr, load_cc, regfilemux_sel, marmux_sel, mdrmux_sel;
  lc3b_sel4mux alumux_sel;
  lc3b_aluop   aluop;
  logic        mem_read, mem_write, mem_error;
  logic [1:0]  mem_byte_enable;
  logic [3:0]  state_dbg;

  control_fsm #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .opcode          (opcode),
    .branch_enable   (branch_enable),
    .imm5_enable     (imm5_enable),
    .imm11_enable    (imm11_enable),
    .mem_resp        (mem_resp),
    .pcmux_sel       (pcmux_sel),
    .load_pc         (load_pc),
    .storemux_sel    (storemux_sel),
    .load_ir         (load_ir),
    .load_regfile    (load_regfile),
    .load_mar        (load_mar),
    .load_mdr        (load_mdr),
    .load_cc         (load_cc),
    .regfilemux_sel  (regfilemux_sel),
    .marmux_sel      (marmux_sel),
    .mdrmux_sel      (mdrmux_sel),
    .alumux_sel      (alumux_sel),
    .aluop           (aluop),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_error       (mem_error),
    .state_dbg       (state_dbg)
  );

  logic [W-1:0] obs;
  assign obs = {pcmux_sel, load_pc, storemux_sel, load_ir, load_regfile, load_mar,
                load_mdr, load_cc, regfilemux_sel, marmux_sel, mdrmux_sel,
                alumux_sel, 3'(aluop), mem_read, mem_write, mem_byte_enable, mem_error};

  // scoreboard
  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];
  int           total = 0;
  int           bad = 0;
  string        cur_tag = "reset";

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check(input logic [W-1:0] o, input logic [W-1:0] e, input string tag);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // driver tasks
  task automatic drive(input stim_t s);
    mem_resp      = s.resp;
    opcode        = lc3b_opcode'(s.op);
    branch_enable = s.br;
    imm5_enable   = s.imm5;
    imm11_enable  = rbit();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      stim_t        s;
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      drive(s);
      @(negedge clk);
      check(obs, e, cur_tag);
      @(posedge clk);
      #1;
    end
  endtask

  // reference model: expected control vectors per cycle of one instruction
  task automatic push(input ctl_t c, input logic resp, input logic [3:0] op,
                      input logic br, input logic imm5);
    exp_q.push_back(c);
    stim_q.push_back('{resp: resp, op: op, br: br, imm5: imm5});
  endtask

  function automatic ctl_t v_fetch1();
    ctl_t c = '0;
    c.marmux_sel = 1'b1; c.load_mar = 1'b1; c.load_pc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_read_wait();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_write_wait();
    ctl_t c = '0;
    c.mem_write = 1'b1; c.mem_byte_enable = 2'b11;
    return c;
  endfunction

  // Memory answers after d unanswered cycles; d < 0 means it never answers.
  task automatic wait_phase(input ctl_t c, input int d, output logic aborted);
    ctl_t ce;
    aborted = 1'b0;
    for (int i = 0; i <= TB_TIMEOUT + 8; i++) begin
      if (d >= 0 && i == d) begin
        push(c, 1'b1, rop(), rbit(), rbit());
        return;
      end else if (TO_EN && i == TB_TIMEOUT) begin
        ce = c;
        ce.mem_error = 1'b1;
        push(ce, 1'b0, rop(), rbit(), rbit());
        aborted = 1'b1;
        return;
      end
      push(c, 1'b0, rop(), rbit(), rbit());
    end
  endtask

  task automatic model_inst(input logic [3:0] op, input logic br, input logic imm5,
                            input int d1, input int d2);
    ctl_t c;
    logic ab;
    push(v_fetch1(), rbit(), rop(), rbit(), rbit());
    wait_phase(v_read_wait(), d1, ab);
    if (ab) return;
    c = '0; c.load_ir = 1'b1;
    push(c, rbit(), rop(), rbit(), rbit());
    push('0, rbit(), op, rbit(), rbit());
    if (op == 4'(op_add) || op == 4'(op_and)) begin
      c = '0;
      c.aluop = (op == 4'(op_and)) ? 3'(alu_and) : 3'(alu_add);
      c.alumux_sel = imm5 ? 2'd2 : 2'd0;
      c.load_regfile = 1'b1; c.load_cc = 1'b1;
      push(c, rbit(), rop(), rbit(), imm5);
    end else if (op == 4'(op_not)) begin
      c = '0;
      c.aluop = 3'(alu_not); c.load_regfile = 1'b1; c.load_cc = 1'b1;
      push(c, rbit(), rop(), rbit(), rbit());
    end else if (op == 4'(op_br)) begin
      push('0, rbit(), rop(), br, rbit());
      if (br) begin
        c = '0; c.pcmux_sel = 1'b1; c.load_pc = 1'b1;
        push(c, rbit(), rop(), rbit(), rbit());
      end
    end else if (op == 4'(op_ldr) || op == 4'(op_str)) begin
      c = '0; c.alumux_sel = 2'd1; c.load_mar = 1'b1;
      push(c, rbit(), op, rbit(), rbit());
      if (op == 4'(op_ldr)) begin
        wait_phase(v_read_wait(), d2, ab);
        if (!ab) begin
          c = '0; c.regfilemux_sel = 1'b1; c.load_regfile = 1'b1; c.load_cc = 1'b1;
          push(c, rbit(), rop(), rbit(), rbit());
        end
      end else begin
        c = '0; c.storemux_sel = 1'b1; c.aluop = 3'(alu_pass); c.load_mdr = 1'b1;
        push(c, rbit(), rop(), rbit(), rbit());
        wait_phase(v_write_wait(), d2, ab);
      end
    end
  endtask

  task automatic run_inst(input string tag, input logic [3:0] op, input logic br,
                          input logic imm5, input int d1, input int d2);
    cur_tag = tag;
    model_inst(op, br, imm5, d1, d2);
    drain();
  endtask

  initial begin
    logic [3:0] ops[7];
    logic [3:0] op;
    ops[0] = 4'(op_add); ops[1] = 4'(op_and); ops[2] = 4'(op_not);
    ops[3] = 4'(op_br);  ops[4] = 4'(op_ldr); ops[5] = 4'(op_str); ops[6] = 4'(op_trap);

    reset_n = 1'b0;
    drive('{resp: 1'b1, op: 4'(op_add), br: 1'b1, imm5: 1'b1});
    cur_tag = "reset_hold";
    push('0, 1'b1, rop(), rbit(), rbit());
    push('0, 1'b0, rop(), rbit(), rbit());
    @(posedge clk);
    #1;
    drain();
    reset_n = 1'b1;

    run_inst("add_imm5", 4'(op_add), 1'b0, 1'b1, 0, 0);
    run_inst("and_sr2", 4'(op_and), 1'b0, 1'b0, 1, 0);
    run_inst("not", 4'(op_not), 1'b0, 1'b0, 0, 0);
    run_inst("br_taken", 4'(op_br), 1'b1, 1'b0, 0, 0);
    run_inst("br_not_taken", 4'(op_br), 1'b0, 1'b0, 0, 0);
    run_inst("ldr", 4'(op_ldr), 1'b0, 1'b0, 0, 2);
    run_inst("str_delay3", 4'(op_str), 1'b0, 1'b0, 0, 3);
    run_inst("op_1111", 4'b1111, 1'b0, 1'b0, 0, 0);

    // reset in the middle of an instruction fetch wait
    cur_tag = "pre_reset";
    push(v_fetch1(), 1'b0, rop(), rbit(), rbit());
    push(v_read_wait(), 1'b0, rop(), rbit(), rbit());
    push(v_read_wait(), 1'b0, rop(), rbit(), rbit());
    drain();
    reset_n = 1'b0;
    #1;
    check(obs, '0, "reset_async");
    cur_tag = "reset_mid_wait";
    push('0, 1'b1, rop(), rbit(), rbit());
    drain();
    reset_n = 1'b1;
    run_inst("after_reset", 4'(op_add), 1'b0, 1'b0, 0, 0);

    if (TO_EN) begin
      run_inst("ldr_timeout", 4'(op_ldr), 1'b0, 1'b0, 0, -1);
      run_inst("ldr_resp_at_limit", 4'(op_ldr), 1'b0, 1'b0, 0, TB_TIMEOUT);
      run_inst("fetch_timeout", 4'(op_add), 1'b0, 1'b0, -1, 0);
      run_inst("str_timeout", 4'(op_str), 1'b0, 1'b0, 1, -1);
      run_inst("fetch_resp_at_limit", 4'(op_not), 1'b0, 1'b0, TB_TIMEOUT, 0);
    end

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 4'(op_trap)) op = rop();
      run_inst("random", op, rbit(), rbit(), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
